// File: rtl/spi_reg_slave.sv
// SPI register-bank responder: eight 8-bit registers reachable from an external
// SPI master (all CPOL/CPHA modes), oversampled in the local clk domain.
module spi_reg_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scki,
  input  logic        ssn,
  input  logic        mosii,
  input  logic        cpol,
  input  logic        cpha,
  output logic        misoo,
  output logic        misoe,
  input  logic        lcl_we,
  input  logic [2:0]  lcl_addr,
  input  logic [7:0]  lcl_wdata,
  output logic [63:0] regs_o,
  output logic        spi_wr,
  output logic [2:0]  spi_waddr,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, IGNORE} state_e;

  // Synchronisers carry no reset so a reset taken with ssn low cannot fake an ssn fall.
  logic [SYNC_STAGES-1:0] sck_sync_q, ssn_sync_q, mosi_sync_q;
  logic                   sck_prev_q, ssn_prev_q;

  always_ff @(posedge clk) begin
    sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], scki};
    ssn_sync_q  <= {ssn_sync_q[SYNC_STAGES-2:0], ssn};
    mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosii};
    sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
    ssn_prev_q  <= ssn_sync_q[SYNC_STAGES-1];
  end

  logic sck_s, ssn_s, mosi_s;
  logic sck_rise, sck_fall, lead_edge, trail_edge, ssn_fall, ssn_rise;

  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign ssn_s      = ssn_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise   = sck_s & ~sck_prev_q;
  assign sck_fall   = ~sck_s & sck_prev_q;
  assign lead_edge  = cpol ? sck_fall : sck_rise;
  assign trail_edge = cpol ? sck_rise : sck_fall;
  assign ssn_fall   = ~ssn_s & ssn_prev_q;
  assign ssn_rise   = ssn_s & ~ssn_prev_q;

  state_e          state_q, state_d;
  logic            sample_q, sample_d, shift_q, shift_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      rx_sr_q, rx_sr_d;
  logic [2:0]      addr_q, addr_d;
  logic            rd_q, rd_d;
  logic [7:0]      tx_sr_q, tx_sr_d;
  logic            fresh_q, fresh_d;
  logic [7:0][7:0] regs_q, regs_d;
  logic            spi_wr_q, spi_wr_d;
  logic [2:0]      spi_waddr_q, spi_waddr_d;
  logic            frame_done_q, frame_done_d;
  logic            misoe_q, misoe_d;
  logic [7:0]      rx_byte;

  assign rx_byte = {rx_sr_q[6:0], mosi_s};

  always_comb begin
    sample_d     = cpha ? trail_edge : lead_edge;
    shift_d      = cpha ? lead_edge : trail_edge;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_sr_d      = rx_sr_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    tx_sr_d      = tx_sr_q;
    fresh_d      = fresh_q;
    regs_d       = regs_q;
    spi_wr_d     = 1'b0;
    spi_waddr_d  = spi_waddr_q;
    frame_done_d = 1'b0;
    misoe_d      = ~ssn_s;

    // Local write first so a same-address SPI write below overrides it.
    if (lcl_we) regs_d[lcl_addr] = lcl_wdata;

    if (ssn_rise) begin
      frame_done_d = (state_q != IDLE);
      state_d      = IDLE;
      tx_sr_d      = 8'd0;
      fresh_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ssn_fall) begin
            state_d   = CMD;
            bit_cnt_d = 3'd0;
            tx_sr_d   = 8'd0;
            fresh_d   = 1'b0;
          end
        end
        CMD, DATA: begin
          // A fresh load holds its MSB through the first shift edge, which makes
          // the same rule work whether that edge precedes or follows sampling.
          if (shift_q) begin
            if (fresh_q) fresh_d = 1'b0;
            else         tx_sr_d = {tx_sr_q[6:0], 1'b0};
          end
          if (sample_q) begin
            rx_sr_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == CMD) begin
                rd_d   = rx_byte[7];
                addr_d = rx_byte[2:0];
                if (rx_byte[6:3] != 4'd0) begin
                  state_d = IGNORE;
                end else begin
                  state_d = DATA;
                  if (rx_byte[7]) begin
                    tx_sr_d = regs_q[rx_byte[2:0]];
                    fresh_d = 1'b1;
                    addr_d  = rx_byte[2:0] + 3'd1;
                  end
                end
              end else if (rd_q) begin
                tx_sr_d = regs_q[addr_q];
                fresh_d = 1'b1;
                addr_d  = addr_q + 3'd1;
              end else begin
                regs_d[addr_q] = rx_byte;
                spi_wr_d       = 1'b1;
                spi_waddr_d    = addr_q;
                addr_d         = addr_q + 3'd1;
              end
            end
          end
        end
        IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sample_q     <= 1'b0;
      shift_q      <= 1'b0;
      bit_cnt_q    <= 3'd0;
      rx_sr_q      <= 8'd0;
      addr_q       <= 3'd0;
      rd_q         <= 1'b0;
      tx_sr_q      <= 8'd0;
      fresh_q      <= 1'b0;
      regs_q       <= '0;
      spi_wr_q     <= 1'b0;
      spi_waddr_q  <= 3'd0;
      frame_done_q <= 1'b0;
      misoe_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_q     <= sample_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_sr_q      <= rx_sr_d;
      addr_q       <= addr_d;
      rd_q         <= rd_d;
      tx_sr_q      <= tx_sr_d;
      fresh_q      <= fresh_d;
      regs_q       <= regs_d;
      spi_wr_q     <= spi_wr_d;
      spi_waddr_q  <= spi_waddr_d;
      frame_done_q <= frame_done_d;
      misoe_q      <= misoe_d;
    end
  end

  assign misoo      = tx_sr_q[7];
  assign misoe      = misoe_q;
  assign regs_o     = regs_q;
  assign spi_wr     = spi_wr_q;
  assign spi_waddr  = spi_waddr_q;
  assign frame_done = frame_done_q;

endmodule
